// File: rtl/mem_stage_sb.sv
// Memory pipeline stage with a FIFO store buffer that drains in the background.
// Define MEM_SB_STORE_FWD_EN to let loads forward from buffered stores instead of stalling.
module mem_stage_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int SB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       RegWrite_in,
  input  logic                       MemToReg_in,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic                       MemSrc,
  input  logic                       ret_in,
  input  logic [REG_W-1:0]           DestReg_in,
  input  logic [ADDR_W-1:0]          MemAcc_addr,
  input  logic [DATA_W-1:0]          MemWrite_data,
  output logic                       out_valid,
  output logic                       RegWrite_out,
  output logic                       MemToReg_out,
  output logic                       ret_out,
  output logic [REG_W-1:0]           DestReg_out,
  output logic [ADDR_W-1:0]          ALU_result_out,
  output logic [DATA_W-1:0]          MemRead_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(SB_DEPTH):0]  sb_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0]   sb_data_q [SB_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                out_valid_q, reg_write_q, mem_to_reg_q, ret_q;
  logic [REG_W-1:0]    dest_reg_q;
  logic [ADDR_W-1:0]   alu_result_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [ADDR_W-1:0]   data_as_addr, eff_addr;
  logic                sb_full, accept, load_hit, load_miss, enq, deq;
  logic [DATA_W-1:0]   fwd_data;

  if (ADDR_W > DATA_W) begin : g_addr_zext
    assign data_as_addr = {{(ADDR_W-DATA_W){1'b0}}, MemWrite_data};
  end else begin : g_addr_trunc
    assign data_as_addr = MemWrite_data[ADDR_W-1:0];
  end

  assign eff_addr = MemSrc ? data_as_addr : MemAcc_addr;
  assign sb_full  = (count_q == CNT_W'(SB_DEPTH));

`ifdef MEM_SB_STORE_FWD_EN
  // Walk from oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    load_hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CNT_W'(i) < count_q && sb_addr_q[rd_ptr_q + PTR_W'(i)] == eff_addr) begin
        load_hit = 1'b1;
        fwd_data = sb_data_q[rd_ptr_q + PTR_W'(i)];
      end
    end
  end
`else
  assign load_hit = 1'b0;
  assign fwd_data = '0;
`endif

  // Full check ignores a same-edge drain so readiness never depends on mem_ack.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == S_LOAD)             in_ready = 1'b0;
    if (state_q == S_DRAIN && MemRead) in_ready = 1'b0;
    if (MemWrite && sb_full)           in_ready = 1'b0;
`ifndef MEM_SB_STORE_FWD_EN
    if (MemRead && count_q != '0)      in_ready = 1'b0;
`endif
  end

  assign accept    = in_valid && in_ready;
  assign load_miss = accept && MemRead && !load_hit;
  assign enq       = accept && MemWrite;
  assign deq       = (state_q == S_DRAIN) && mem_req_q && mem_ack;
  assign count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);

  // NOTE: buffer storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr_q[wr_ptr_q] <= eff_addr;
      sb_data_q[wr_ptr_q] <= MemWrite_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      ret_q        <= 1'b0;
      dest_reg_q   <= '0;
      alu_result_q <= '0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= 1'b0;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;

      // A load miss holds its controls here and raises out_valid only when memory answers.
      if (accept) begin
        reg_write_q  <= RegWrite_in;
        mem_to_reg_q <= MemToReg_in;
        ret_q        <= ret_in;
        dest_reg_q   <= DestReg_in;
        alu_result_q <= MemAcc_addr;
        out_valid_q  <= !load_miss;
        rdata_q      <= load_hit ? fwd_data : '0;
      end

      case (state_q)
        S_IDLE: begin
          if (load_miss) begin
            state_q     <= S_LOAD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= eff_addr;
            mem_wdata_q <= '0;
          end else if (count_q != '0) begin
            state_q     <= S_DRAIN;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= sb_addr_q[rd_ptr_q];
            mem_wdata_q <= sb_data_q[rd_ptr_q];
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (mem_ack) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
            rdata_q     <= mem_rdata;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign RegWrite_out   = reg_write_q;
  assign MemToReg_out   = mem_to_reg_q;
  assign ret_out        = ret_q;
  assign DestReg_out    = dest_reg_q;
  assign ALU_result_out = alu_result_q;
  assign MemRead_data   = rdata_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign sb_count       = count_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Scoreboard bench for mem_stage_sb: architectural memory model, delayed-ack memory responder.
// Directed cases follow by randomized traffic; works with or without MEM_SB_STORE_FWD_EN.
module tb_mem_stage_sb;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int REG_W    = 5;
  localparam int SB_DEPTH = 4;

  typedef logic [95:0] w_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      RegWrite_in = 1'b0, MemToReg_in = 1'b0, MemRead = 1'b0;
  logic                      MemWrite = 1'b0, MemSrc = 1'b0, ret_in = 1'b0;
  logic [REG_W-1:0]          DestReg_in = '0;
  logic [ADDR_W-1:0]         MemAcc_addr = '0;
  logic [DATA_W-1:0]         MemWrite_data = '0;
  logic                      out_valid, RegWrite_out, MemToReg_out, ret_out;
  logic [REG_W-1:0]          DestReg_out;
  logic [ADDR_W-1:0]         ALU_result_out;
  logic [DATA_W-1:0]         MemRead_data;
  logic                      mem_req, mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ack = 1'b0;
  logic [DATA_W-1:0]         mem_rdata = '0;
  logic [$clog2(SB_DEPTH):0] sb_count;

  mem_stage_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSrc(MemSrc), .ret_in(ret_in), .DestReg_in(DestReg_in),
    .MemAcc_addr(MemAcc_addr), .MemWrite_data(MemWrite_data), .out_valid(out_valid),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .ret_out(ret_out),
    .DestReg_out(DestReg_out), .ALU_result_out(ALU_result_out), .MemRead_data(MemRead_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rw, mtr, ret;
    logic [REG_W-1:0]  dest;
    logic [ADDR_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
  } res_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  res_t              res_q[$];
  wr_t               wq[$];
  logic [DATA_W-1:0] phys_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] arch_mem [logic [ADDR_W-1:0]];

  int n_cmp = 0, n_fail = 0;
  bit accepted = 1'b0, chk_ov = 1'b0, ack_enable = 1'b1;
  int fixed_delay = -1;
  int read_cnt = 0;

  task automatic check(input string name, input w_t act, input w_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [DATA_W-1:0] arch_rd(input logic [ADDR_W-1:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] phys_rd(input logic [ADDR_W-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  // Program-order memory: a load sees the latest earlier store, whatever the buffer state.
  task automatic model_accept();
    res_t              r;
    logic [ADDR_W-1:0] ea;
    ea      = MemSrc ? MemWrite_data : MemAcc_addr;
    r.rw    = RegWrite_in;
    r.mtr   = MemToReg_in;
    r.ret   = ret_in;
    r.dest  = DestReg_in;
    r.alu   = MemAcc_addr;
    r.rdata = '0;
    if (MemWrite) begin
      wq.push_back('{addr: ea, data: MemWrite_data});
      arch_mem[ea] = MemWrite_data;
    end else if (MemRead) begin
      r.rdata = arch_rd(ea);
    end
    res_q.push_back(r);
    chk_ov = !MemRead;
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_ov) begin
      check("latency1_out_valid", w_t'(out_valid), w_t'(1));
      chk_ov = 1'b0;
    end
    accepted = in_valid && in_ready;
    if (accepted) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mr, input bit mw, input bit ms,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    in_valid      = 1'b1;
    MemRead       = mr;
    MemWrite      = mw;
    MemSrc        = ms;
    MemAcc_addr   = addr;
    MemWrite_data = wdata;
    RegWrite_in   = 1'($urandom_range(0, 1));
    MemToReg_in   = 1'($urandom_range(0, 1));
    ret_in        = 1'($urandom_range(0, 1));
    DestReg_in    = REG_W'($urandom);
  endtask

  task automatic send(input bit mr, input bit mw, input bit ms,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    drive(mr, mw, ms, addr, wdata);
    for (int t = 0; t < 300; t++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done     = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      if (sb_count == 0 && !mem_req) done = 1'b1;
      else step();
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    res_q.delete();
    wq.delete();
    arch_mem = phys_mem;
    chk_ov   = 1'b0;
  endtask

  // Result monitor: every out_valid pulse retires the oldest expected result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (res_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          e = res_q.pop_front();
          check("res_ctrl", w_t'({RegWrite_out, MemToReg_out, ret_out, DestReg_out}),
                w_t'({e.rw, e.mtr, e.ret, e.dest}));
          check("res_alu", w_t'(ALU_result_out), w_t'(e.alu));
          check("res_rdata", w_t'(MemRead_data), w_t'(e.rdata));
        end
      end
    end
  end

  // Memory responder: acks after a delay, checks request stability and drain order.
  initial begin
    bit                pend;
    int                wait_cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    wr_t               w;
    pend     = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = DATA_W'($urandom);
      if (!mem_req || rst) begin
        pend = 1'b0;
        continue;
      end
      if (!pend) begin
        pend      = 1'b1;
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        wait_cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end else begin
        check("mem_req_stable_addr", w_t'({mem_we, mem_addr}), w_t'({cap_we, cap_addr}));
        check("mem_req_stable_wdata", w_t'(mem_wdata), w_t'(cap_wdata));
      end
      if (ack_enable && wait_cnt == 0) begin
        mem_ack = 1'b1;
        pend    = 1'b0;
        if (mem_we) begin
          if (wq.size() == 0) begin
            fail_now("unexpected_drain");
          end else begin
            w = wq.pop_front();
            check("drain_addr", w_t'(mem_addr), w_t'(w.addr));
            check("drain_data", w_t'(mem_wdata), w_t'(w.data));
          end
          phys_mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = phys_rd(mem_addr);
          read_cnt++;
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", w_t'(out_valid), w_t'(0));
    check("rst_in_ready", w_t'(in_ready), w_t'(1));
    check("rst_mem_req", w_t'({mem_req, mem_we}), w_t'(0));
    check("rst_mem_addr", w_t'({mem_addr, mem_wdata}), w_t'(0));
    check("rst_sb_count", w_t'(sb_count), w_t'(0));
    check("rst_outputs", w_t'({MemRead_data, ALU_result_out, DestReg_out}), w_t'(0));
    @(posedge clk);
    #1;

    // Plain ALU op: one-cycle latency, no memory traffic
    send(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("alu_op_out_valid", w_t'(out_valid), w_t'(1));
    check("alu_op_result", w_t'(ALU_result_out), w_t'(32'h10));
    check("alu_op_mem_req", w_t'(mem_req), w_t'(0));
    chk_ov = 1'b0;
    @(posedge clk);
    #1;

    // Fill the buffer with memory stalled; fifth store must be refused
    fixed_delay = 0;
    ack_enable  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom);
      check("fill_store_accepted", w_t'(accepted), w_t'(1));
    end
    drive(1'b0, 1'b1, 1'b0, 32'h110, 32'h5555_0005);
    step();
    check("fifth_store_refused", w_t'(accepted), w_t'(0));
    check("full_sb_count", w_t'(sb_count), w_t'(SB_DEPTH));
    ack_enable = 1'b1;
    step();
    check("full_refused_on_drain_edge", w_t'(accepted), w_t'(0));
    step();
    check("store_after_drain", w_t'(accepted), w_t'(1));
    in_valid    = 1'b0;
    fixed_delay = -1;
    wait_drain();

    // Two stores to one address, then a load of it
    fixed_delay = 2;
    rc = read_cnt;
    send(1'b0, 1'b1, 1'b0, 32'h40, 32'hAAAA);
    send(1'b0, 1'b1, 1'b0, 32'h40, 32'hBBBB);
    send(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
`ifdef MEM_SB_STORE_FWD_EN
    @(negedge clk);
    check("fwd_out_valid", w_t'(out_valid), w_t'(1));
    check("fwd_data", w_t'(MemRead_data), w_t'(32'hBBBB));
    @(posedge clk);
    #1;
    wait_drain();
    check("fwd_no_read_req", w_t'(read_cnt), w_t'(rc));
`else
    wait_drain();
    check("stall_load_one_read", w_t'(read_cnt), w_t'(rc + 1));
`endif

    // Load miss with a three-cycle ack delay
    phys_mem[32'h80] = 32'h1234;
    arch_mem[32'h80] = 32'h1234;
    fixed_delay = 3;
    send(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("load_wait_no_valid", w_t'(out_valid), w_t'(0));
    end
    @(negedge clk);
    check("load_valid_after_ack", w_t'(out_valid), w_t'(1));
    check("load_data", w_t'(MemRead_data), w_t'(32'h1234));
    @(posedge clk);
    #1;
    fixed_delay = -1;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * i), $urandom);
    wait_drain();

    // Reset while a drain waits for its ack
    fixed_delay = 0;
    ack_enable  = 1'b0;
    send(1'b0, 1'b1, 1'b0, 32'h500, 32'hDEAD_0001);
    send(1'b0, 1'b1, 1'b0, 32'h504, 32'hDEAD_0002);
    for (int t = 0; t < 20 && !(mem_req && mem_we); t++) step();
    check("drain_started", w_t'({mem_req, mem_we}), w_t'(2'b11));
    do_reset();
    @(negedge clk);
    check("rst_drain_mem_req", w_t'(mem_req), w_t'(0));
    check("rst_drain_sb_count", w_t'(sb_count), w_t'(0));
    check("rst_drain_in_ready", w_t'(in_ready), w_t'(1));
    @(posedge clk);
    #1;
    ack_enable  = 1'b1;
    fixed_delay = -1;
    send(1'b0, 1'b0, 1'b0, 32'h77, 32'h0);
    send(1'b0, 1'b1, 1'b0, 32'h500, 32'h0BAD_CAFE);
    send(1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    send(1'b1, 1'b0, 1'b0, 32'h504, 32'h0);
    wait_drain();

    // Randomized traffic over a small address pool
    for (int n = 0; n < 400; n++) begin
      int                kind;
      bit                ms;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      kind = int'($urandom_range(0, 99));
      a    = 32'h200 + 32'(4 * $urandom_range(0, 7));
      ms   = ($urandom_range(0, 3) == 0);
      d    = ms ? a : DATA_W'($urandom);
      if (kind < 30)      send(1'b0, 1'b0, 1'(ms), DATA_W'($urandom), d);
      else if (kind < 65) send(1'b0, 1'b1, 1'(ms), ms ? DATA_W'($urandom) : a, d);
      else                send(1'b1, 1'b0, 1'(ms), ms ? DATA_W'($urandom) : a, d);
      if ($urandom_range(0, 3) == 0) step();
    end
    wait_drain();
    repeat (3) step();
    check("final_results_pending", w_t'(res_q.size()), w_t'(0));
    check("final_drains_pending", w_t'(wq.size()), w_t'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
